// File: rtl/corescore_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module      : corescore_stream_fifo
// Description : Byte-wide AXI-stream style FIFO between the corescore stream
//               source and the UART emitter. Stores {tlast, tdata} entries in
//               a circular buffer with first-word fall-through output.
//               Define CORESCORE_FIFO_PKT_EN to select store-and-forward mode,
//               in which output is held until a complete packet is stored.
//               The FIFO is also released when it becomes full, so that
//               packets longer than DEPTH do not deadlock.
// Revision    : 1.0 - initial release
// ============================================================================
module corescore_stream_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [7:0]    i_tdata,
    input  logic          i_tlast,
    input  logic          i_tvalid,
    output logic          o_tready,
    output logic [7:0]    o_tdata,
    output logic          o_tlast,
    output logic          o_tvalid,
    input  logic          i_tready,
    output logic [AW:0]   o_level
);

    localparam logic [AW:0]   c_full    = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_lvl_one = (AW+1)'(1);
    localparam logic [AW-1:0] c_ptr_one = AW'(1);

    // Storage is not reset; the level/valid logic keeps stale entries hidden.
    logic [8:0]    mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q,  level_d;
    logic          ready_q,  ready_d;

    logic          w_wr_en;
    logic          w_rd_en;
    logic          w_valid;

    // Handshakes only ever look at registered state, so there is no
    // combinational path from i_tvalid to o_tvalid.
    always_comb begin
        w_wr_en = i_tvalid && ready_q;
        w_rd_en = w_valid && i_tready;
    end

    // Pointer and level next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (w_wr_en) begin
            wr_ptr_d = wr_ptr_q + c_ptr_one;
        end
        if (w_rd_en) begin
            rd_ptr_d = rd_ptr_q + c_ptr_one;
        end
        case ({w_wr_en, w_rd_en})
            2'b10:   level_d = level_q + c_lvl_one;
            2'b01:   level_d = level_q - c_lvl_one;
            default: level_d = level_q;
        endcase
        // Ready is registered from the next level, so it stays low during
        // reset and rises on the first clock edge after release.
        ready_d = (level_d != c_full);
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ready_q  <= ready_d;
        end
    end

    // Entry storage written on an accepted upstream byte.
    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            mem_q[wr_ptr_q] <= {i_tlast, i_tdata};
        end
    end

`ifdef CORESCORE_FIFO_PKT_EN
    logic [AW:0] pkt_q, pkt_d;
    logic        w_pkt_inc;
    logic        w_pkt_dec;

    // Count complete packets held; a simultaneous end-of-packet in and out
    // leaves the count unchanged.
    always_comb begin
        w_pkt_inc = w_wr_en && i_tlast;
        w_pkt_dec = w_rd_en && o_tlast;
        case ({w_pkt_inc, w_pkt_dec})
            2'b10:   pkt_d = pkt_q + c_lvl_one;
            2'b01:   pkt_d = pkt_q - c_lvl_one;
            default: pkt_d = pkt_q;
        endcase
    end

    // Packet counter register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pkt_q <= '0;
        end else begin
            pkt_q <= pkt_d;
        end
    end

    // Present data once a whole packet is stored, or when full (release).
    always_comb begin
        w_valid = (level_q != '0) && ((pkt_q != '0) || (level_q == c_full));
    end
`else
    // Cut-through: any stored entry is presented.
    always_comb begin
        w_valid = (level_q != '0);
    end
`endif

    // Output drive: first-word fall-through from the read pointer.
    always_comb begin
        o_tvalid = w_valid;
        o_tready = ready_q;
        o_level  = level_q;
        o_tdata  = mem_q[rd_ptr_q][7:0];
        o_tlast  = mem_q[rd_ptr_q][8];
    end

endmodule
`default_nettype wire

// File: tb/tb_corescore_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_corescore_stream_fifo
// Description : Self-checking bench for corescore_stream_fifo. A queue-based
//               reference model predicts level, ready, valid and head data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_corescore_stream_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    i_tdata = '0;
    logic          i_tlast = 1'b0;
    logic          i_tvalid = 1'b0;
    logic          o_tready;
    logic [7:0]    o_tdata;
    logic          o_tlast;
    logic          o_tvalid;
    logic          i_tready = 1'b0;
    logic [AW:0]   o_level;

    corescore_stream_fifo #(.DEPTH(DEPTH)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_tdata  (i_tdata),
        .i_tlast  (i_tlast),
        .i_tvalid (i_tvalid),
        .o_tready (o_tready),
        .o_tdata  (o_tdata),
        .o_tlast  (o_tlast),
        .o_tvalid (o_tvalid),
        .i_tready (i_tready),
        .o_level  (o_level)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [8:0] q[$];
    bit         m_ready = 1'b0;
    int         n_out = 0;

    typedef struct {
        logic       tv;
        logic [7:0] td;
        logic       tl;
        logic       rd;
        int         lvl;
        logic       vld;
        logic [7:0] od;
        logic       ol;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    function automatic int m_pkts();
        int n = 0;
        foreach (q[i]) if (q[i][8]) n++;
        return n;
    endfunction

    function automatic bit m_valid();
`ifdef CORESCORE_FIFO_PKT_EN
        return (q.size() != 0) && ((m_pkts() != 0) || (q.size() == DEPTH));
`else
        return (q.size() != 0);
`endif
    endfunction

    task automatic check_model();
        check("level", int'(o_level), q.size());
        check("ready", int'(o_tready), int'(m_ready));
        check("valid", int'(o_tvalid), int'(m_valid()));
        if (m_valid()) begin
            check("tdata", int'(o_tdata), int'(q[0][7:0]));
            check("tlast", int'(o_tlast), int'(q[0][8]));
        end
    endtask

    // One clock: drive inputs, advance, update model, compare.
    task automatic drive_edge(input logic tv, input logic [7:0] td,
                              input logic tl, input logic rd);
        bit w;
        bit r;
        i_tvalid = tv;
        i_tdata  = td;
        i_tlast  = tl;
        i_tready = rd;
        w = tv && m_ready;
        r = m_valid() && rd;
        if (r) n_out++;
        @(posedge clk);
        #1;
        if (r) void'(q.pop_front());
        if (w) q.push_back({tl, td});
        m_ready = (q.size() != DEPTH);
        check_model();
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        i_tvalid = 1'b0;
        i_tready = 1'b0;
        #1;
        q.delete();
        m_ready = 1'b0;
        check("rst_level", int'(o_level), 0);
        check("rst_valid", int'(o_tvalid), 0);
        check("rst_ready", int'(o_tready), 0);
        @(posedge clk);
        #1;
        check("rst_hold_ready", int'(o_tready), 0);
        rst = 1'b0;
    endtask

    // Global time bound.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[8];
        int   k;
        bit   acc;

        tbl[0] = '{1'b1, 8'h41, 1'b0, 1'b1, 1, 1'b1, 8'h41, 1'b0};
        tbl[1] = '{1'b1, 8'h42, 1'b1, 1'b1, 1, 1'b1, 8'h42, 1'b1};
        tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 8'h00, 1'b0};
        tbl[3] = '{1'b1, 8'h55, 1'b0, 1'b0, 1, 1'b1, 8'h55, 1'b0};
        tbl[4] = '{1'b1, 8'h66, 1'b1, 1'b0, 2, 1'b1, 8'h55, 1'b0};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 2, 1'b1, 8'h55, 1'b0};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1, 1'b1, 8'h66, 1'b1};
        tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 8'h00, 1'b0};

        #1;
        do_reset();
        drive_edge(1'b0, 8'h00, 1'b0, 1'b0);
        check("ready_after_release", int'(o_tready), 1);

`ifndef CORESCORE_FIFO_PKT_EN
        // Cut-through table: latency, back-to-back, stall stability.
        foreach (tbl[i]) begin
            drive_edge(tbl[i].tv, tbl[i].td, tbl[i].tl, tbl[i].rd);
            check($sformatf("tbl%0d_level", i), int'(o_level), tbl[i].lvl);
            check($sformatf("tbl%0d_valid", i), int'(o_tvalid), int'(tbl[i].vld));
            if (tbl[i].vld) begin
                check($sformatf("tbl%0d_tdata", i), int'(o_tdata), int'(tbl[i].od));
                check($sformatf("tbl%0d_tlast", i), int'(o_tlast), int'(tbl[i].ol));
            end
        end
`else
        // Store-and-forward: partial packet held, tlast releases it.
        drive_edge(1'b1, 8'h10, 1'b0, 1'b1);
        drive_edge(1'b1, 8'h11, 1'b0, 1'b1);
        drive_edge(1'b1, 8'h12, 1'b0, 1'b1);
        check("pkt_hold_valid", int'(o_tvalid), 0);
        drive_edge(1'b1, 8'h0A, 1'b1, 1'b1);
        check("pkt_release_valid", int'(o_tvalid), 1);
        check("pkt_release_head", int'(o_tdata), 8'h10);
        for (int c = 0; c < 4; c++) drive_edge(1'b0, 8'h00, 1'b0, 1'b1);
        check("pkt_drained", int'(o_level), 0);

        // Packet longer than DEPTH: full-FIFO release.
        k = 0;
        while (q.size() < DEPTH) begin
            acc = m_ready;
            drive_edge(1'b1, 8'(8'hC0 + k), 1'b0, 1'b0);
            if (acc) k++;
        end
        check("long_pkt_release", int'(o_tvalid), 1);
        n_out = 0;
        for (int c = 0; c < 300 && (k < 18 || q.size() != 0); c++) begin
            acc = m_ready;
            drive_edge(k < 18, 8'(8'hC0 + k), k == 17, 1'b1);
            if (acc && k < 18) k++;
        end
        check("long_pkt_count", n_out, 18);
`endif

        // Fill with downstream stalled, then drain.
        k = 0;
        for (int c = 0; c < 20; c++) begin
            acc = m_ready;
            drive_edge(1'b1, 8'(8'h80 + k), k == 19, 1'b0);
            if (acc) k++;
        end
        check("full_accepted", k, 16);
        check("full_level", int'(o_level), 16);
        check("full_ready", int'(o_tready), 0);
        n_out = 0;
        for (int c = 0; c < 300 && (k < 20 || q.size() != 0); c++) begin
            acc = m_ready;
            drive_edge(k < 20, 8'(8'h80 + k), k == 19, 1'b1);
            if (acc && k < 20) k++;
        end
        check("drain_count", n_out, 20);

        // Steady state at level 5.
        for (int c = 0; c < 5; c++) drive_edge(1'b1, 8'(8'h20 + c), 1'b1, 1'b0);
        for (int c = 0; c < 100; c++) drive_edge(1'b1, 8'(c), 1'b1, 1'b1);
        check("steady_level", int'(o_level), 5);
        for (int c = 0; c < 10; c++) drive_edge(1'b0, 8'h00, 1'b0, 1'b1);
        check("steady_drained", int'(o_level), 0);

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            drive_edge(($urandom % 4) != 0, 8'($urandom),
                       ($urandom % 4) == 0, ($urandom % 3) != 0);
        end
        for (int c = 0; c < 300 && q.size() != 0; c++) begin
            drive_edge(1'b0, 8'h00, 1'b1, 1'b1);
        end
        check("random_drained", int'(o_level), 0);

        // Asynchronous reset mid-packet.
        for (int c = 0; c < 7; c++) drive_edge(1'b1, 8'(8'h60 + c), 1'b0, 1'b0);
        check("pre_rst_level", int'(o_level), 7);
        i_tvalid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_valid", int'(o_tvalid), 0);
        check("async_rst_level", int'(o_level), 0);
        q.delete();
        m_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive_edge(1'b0, 8'h00, 1'b0, 1'b0);
        drive_edge(1'b1, 8'hA5, 1'b1, 1'b0);
        check("post_rst_valid", int'(o_tvalid), 1);
        check("post_rst_data", int'(o_tdata), 8'hA5);
        check("post_rst_last", int'(o_tlast), 1);
        drive_edge(1'b0, 8'h00, 1'b0, 1'b1);
        check("post_rst_empty", int'(o_level), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/corescore_stream_fifo.md
CORESCORE_STREAM_FIFO -- requirements
Module: corescore_stream_fifo

Interface
REQ-001 Parameter DEPTH, default 16: number of entries; power of two, range 2..256.
REQ-002 Parameter AW, default $clog2(DEPTH): pointer width, derived; not overridden by users.
REQ-003 i_clk  in  1  single clock; all state updates on its rising edge.
REQ-004 i_rst  in  1  reset, asynchronous assert, active-high.
REQ-005 i_tdata  in  8  upstream byte, from the corescorecore stream output.
REQ-006 i_tlast  in  1  upstream end-of-packet marker.
REQ-007 i_tvalid  in  1  upstream byte valid.
REQ-008 o_tready  out  1  FIFO accepts upstream byte.
REQ-009 o_tdata  out  8  downstream byte, to the UART emitter.
REQ-010 o_tlast  out  1  downstream end-of-packet marker.
REQ-011 o_tvalid  out  1  downstream byte valid.
REQ-012 i_tready  in  1  downstream accepts byte.
REQ-013 o_level  out  AW+1  current number of stored entries, 0..DEPTH.

Function
REQ-014 Storage: DEPTH x 9 bits holding {tlast, tdata}, circular; write and read pointers are AW bits and wrap from DEPTH-1 to 0.
REQ-015 Write handshake: a write occurs in a cycle where i_tvalid && o_tready; o_tready = (o_level != DEPTH), driven from registered state only.
REQ-016 Read handshake: a read occurs in a cycle where o_tvalid && i_tready; o_tdata/o_tlast show the entry at the read pointer (first-word fall-through).
REQ-017 Latency: a byte written in cycle N is presented with o_tvalid high from cycle N+1 when the FIFO was empty; there is no combinational path from i_tvalid to o_tvalid.
REQ-018 o_tdata/o_tlast remain stable while o_tvalid && !i_tready; o_tvalid never deasserts without a completed read.
REQ-019 Level: o_level increments on write-only, decrements on read-only, and is unchanged on simultaneous write and read.
REQ-020 Full (o_level == DEPTH): o_tready low, no write; a read in that cycle frees one entry, so o_tready is high from the next cycle.
REQ-021 Empty (o_level == 0): o_tvalid low; a write in that cycle does not bypass to the output in the same cycle.
REQ-022 Simultaneous read and write at any non-full, non-empty level: both are performed and ordering is preserved.

Reset
REQ-023 While i_rst is high: pointers = 0, o_level = 0, o_tvalid = 0, o_tready = 0, packet counter = 0.
REQ-024 o_tready rises in the first cycle after i_rst deasserts; memory contents are not reset and are never visible while empty.
REQ-025 Reset asserted mid-packet discards all stored bytes immediately (asynchronous); no partial packet is emitted after release.

Configuration
REQ-026 Macro CORESCORE_FIFO_PKT_EN selects store-and-forward mode.
REQ-027 With CORESCORE_FIFO_PKT_EN defined:
- AW+1-bit packet counter tracks complete packets stored; it increments on a write with i_tlast=1 and decrements on a read with o_tlast=1.
- Simultaneous increment and decrement leave the counter unchanged.
- o_tvalid = (o_level != 0) && ((packet count != 0) || (o_level == DEPTH)).
- Full-FIFO release rule prevents deadlock on packets longer than DEPTH.
REQ-028 Without CORESCORE_FIFO_PKT_EN: cut-through; o_tvalid = (o_level != 0); no packet counter is synthesised.

Verification
REQ-029 Write 0x41, 0x42 (tlast on 0x42), i_tready=1 -> cut-through: 0x41 out in cycle N+1, 0x42 with o_tlast=1 in cycle N+2.
REQ-030 DEPTH=16, i_tready=0, 20 bytes offered -> o_tready low after 16 accepted, o_level=16; raise i_tready -> all 16 bytes out in order with no loss or duplication, then the remaining 4 bytes follow.
REQ-031 Continuous i_tvalid=1 and i_tready=1 with level held at 5 for 100 cycles -> o_level stays 5 and the output equals the input sequence delayed.
REQ-032 PKT_EN: write 0x10, 0x11, 0x12 without tlast -> o_tvalid stays 0; write 0x0A with tlast -> o_tvalid=1 next cycle and 4 bytes drain.
REQ-033 PKT_EN, DEPTH=16: write an 18-byte packet -> at level 16, o_tvalid=1 (release), drains, and all 18 bytes pass.
REQ-034 Assert i_rst with level 7 mid-packet -> o_tvalid=0 and o_level=0 immediately; after release, the first new byte written appears unchanged.
